mdu_hilo: RTL and testbench

//  Multiply/divide unit with architectural HI/LO registers, in the EX stage beside the ALU.

---
 rtl/mdu_hilo_pkg.sv | 21 ++
 rtl/mdu_hilo.sv | 146 ++++++++++++++
 tb/tb_mdu_hilo.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/mdu_hilo_pkg.sv
// Shared encodings and helpers for the HI/LO multiply/divide unit.
package mdu_hilo_pkg;

   typedef enum logic [1:0] {
      MD_MULT  = 2'd0,
      MD_MULTU = 2'd1,
      MD_DIV   = 2'd2,
      MD_DIVU  = 2'd3
   } md_op_e;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } md_state_e;

   // Two's-complement magnitude; 0x80000000 maps to itself, read as unsigned 2^31.
   function automatic logic [31:0] abs32(input logic [31:0] v);
      return v[31] ? (~v + 32'd1) : v;
   endfunction

endpackage

// File: rtl/mdu_hilo.sv
// Multiply/divide unit with architectural HI/LO registers (EX stage).
// The cycle counter only models latency; the arithmetic is combinational on the
// latched operands and is captured into HI/LO on the final busy edge.
//
// state   | meaning
// --------+------------------------------------------------------------
// ST_IDLE | no operation in flight; start launches, mthi/mtlo write
// ST_RUN  | operation in flight; count_q counts down, commit at zero
module mdu_hilo
   import mdu_hilo_pkg::*;
#(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [1:0]  md_op,
   input  logic        mt_hi,
   input  logic        mt_lo,
   input  logic [31:0] A,
   input  logic [31:0] B,
   output logic        busy,
   output logic        md_stall,
   output logic [31:0] HI,
   output logic [31:0] LO
);

   localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
   localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
   localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

   md_state_e        state_q;
   md_op_e           op_q;
   logic [CNT_W-1:0] count_q;
   logic [31:0]      a_q;
   logic [31:0]      b_q;
   logic             busy_q;
   logic [31:0]      hi_q;
   logic [31:0]      lo_q;

   logic [31:0]      res_hi_d;
   logic [31:0]      res_lo_d;
   logic             res_we_d;

   logic [63:0]      prod;
   logic [31:0]      a_mag;
   logic [31:0]      b_mag;
   logic [31:0]      uq;
   logic [31:0]      ur;

   // Result of the latched operation; divide-by-zero suppresses the write.
   always_comb begin
      res_hi_d = hi_q;
      res_lo_d = lo_q;
      res_we_d = 1'b0;
      prod     = '0;
      a_mag    = abs32(a_q);
      b_mag    = abs32(b_q);
      uq       = '0;
      ur       = '0;
      case (op_q)
         MD_MULT: begin
            prod     = $signed({{32{a_q[31]}}, a_q}) * $signed({{32{b_q[31]}}, b_q});
            res_hi_d = prod[63:32];
            res_lo_d = prod[31:0];
            res_we_d = 1'b1;
         end
         MD_MULTU: begin
            prod     = {32'd0, a_q} * {32'd0, b_q};
            res_hi_d = prod[63:32];
            res_lo_d = prod[31:0];
            res_we_d = 1'b1;
         end
         MD_DIV: begin
            // Divide magnitudes then restore signs: quotient truncates toward zero,
            // remainder follows the dividend; 0x80000000 / -1 wraps to 0x80000000.
            if (b_q != 32'd0) begin
               uq       = a_mag / b_mag;
               ur       = a_mag % b_mag;
               res_lo_d = (a_q[31] ^ b_q[31]) ? (~uq + 32'd1) : uq;
               res_hi_d = a_q[31] ? (~ur + 32'd1) : ur;
               res_we_d = 1'b1;
            end
         end
         MD_DIVU: begin
            if (b_q != 32'd0) begin
               res_lo_d = a_q / b_q;
               res_hi_d = a_q % b_q;
               res_we_d = 1'b1;
            end
         end
         default: ;
      endcase
   end

   // Launch/count/commit sequencing plus idle mthi/mtlo writes.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         op_q    <= MD_MULT;
         count_q <= '0;
         a_q     <= '0;
         b_q     <= '0;
         busy_q  <= 1'b0;
         hi_q    <= '0;
         lo_q    <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  state_q <= ST_RUN;
                  op_q    <= md_op_e'(md_op);
                  a_q     <= A;
                  b_q     <= B;
                  count_q <= md_op[1] ? DIV_LOAD : MULT_LOAD;
                  busy_q  <= 1'b1;
               end else begin
                  if (mt_hi) hi_q <= A;
                  if (mt_lo) lo_q <= A;
               end
            end
            ST_RUN: begin
               if (count_q == '0) begin
                  state_q <= ST_IDLE;
                  busy_q  <= 1'b0;
                  if (res_we_d) begin
                     hi_q <= res_hi_d;
                     lo_q <= res_lo_d;
                  end
               end else begin
                  count_q <= count_q - 1'b1;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign busy     = busy_q;
   assign md_stall = busy_q | start;
   assign HI       = hi_q;
   assign LO       = lo_q;

endmodule

// File: tb/tb_mdu_hilo.sv
// Bench for mdu_hilo: directed operations push expected HI/LO and busy length
// into a queue; a monitor pops and compares on every busy falling edge.
module tb_mdu_hilo;
   import mdu_hilo_pkg::*;

   logic        clk;
   logic        reset;
   logic        start;
   logic [1:0]  md_op;
   logic        mt_hi;
   logic        mt_lo;
   logic [31:0] A;
   logic [31:0] B;
   logic        busy;
   logic        md_stall;
   logic [31:0] HI;
   logic [31:0] LO;

   typedef struct {
      logic [31:0] hi;
      logic [31:0] lo;
      int          cycles;
   } exp_t;

   exp_t sb[$];
   int   errors = 0;
   int   checks = 0;

   mdu_hilo #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
      .clk(clk), .reset(reset), .start(start), .md_op(md_op),
      .mt_hi(mt_hi), .mt_lo(mt_lo), .A(A), .B(B),
      .busy(busy), .md_stall(md_stall), .HI(HI), .LO(LO)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
      end
   endtask

   // Monitor: on each busy fall (reset high) pop and compare the commit.
   initial begin
      logic prev;
      int   len;
      exp_t e;
      prev = 1'b0;
      len  = 0;
      forever begin
         @(negedge clk);
         if (!reset) begin
            prev = 1'b0;
            len  = 0;
         end else begin
            if (busy) begin
               len++;
            end else if (prev) begin
               if (sb.size() == 0) begin
                  check("unexpected_commit", 64'd1, 64'd0);
               end else begin
                  e = sb.pop_front();
                  check("commit_hi", {32'd0, HI}, {32'd0, e.hi});
                  check("commit_lo", {32'd0, LO}, {32'd0, e.lo});
                  check("busy_len", 64'(len), 64'(e.cycles));
               end
               len = 0;
            end
            prev = busy;
         end
      end
   end

   logic [31:0] hi0, lo0;

   task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic mth, input logic [31:0] ehi, input logic [31:0] elo,
                        input int n);
      exp_t e;
      @(posedge clk); #1;
      hi0   = HI;
      lo0   = LO;
      start = 1'b1;
      md_op = op;
      A     = a;
      B     = b;
      mt_hi = mth;
      #1;
      check("md_stall_on_start", {63'd0, md_stall}, 64'd1);
      e.hi = ehi; e.lo = elo; e.cycles = n;
      sb.push_back(e);
      @(posedge clk); #1;
      start = 1'b0;
      mt_hi = 1'b0;
      check("busy_after_start", {63'd0, busy}, 64'd1);
      check("hi_held_at_start", {32'd0, HI}, {32'd0, hi0});
   endtask

   task automatic wait_done();
      logic changed;
      logic done;
      changed = 1'b0;
      done    = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (!busy) begin
            done = 1'b1;
            break;
         end
         if (HI !== hi0 || LO !== lo0) changed = 1'b1;
      end
      check("done_in_budget", {63'd0, done}, 64'd1);
      check("hilo_hold_during_run", {63'd0, changed}, 64'd0);
   endtask

   task automatic mt(input logic h, input logic l, input logic [31:0] a,
                     input logic [31:0] ehi, input logic [31:0] elo);
      @(posedge clk); #1;
      mt_hi = h;
      mt_lo = l;
      A     = a;
      #1;
      check("md_stall_mt", {63'd0, md_stall}, 64'd0);
      @(posedge clk); #1;
      mt_hi = 1'b0;
      mt_lo = 1'b0;
      check("mt_hi_val", {32'd0, HI}, {32'd0, ehi});
      check("mt_lo_val", {32'd0, LO}, {32'd0, elo});
      check("mt_no_busy", {63'd0, busy}, 64'd0);
   endtask

   initial begin
      reset = 1'b0;
      start = 1'b0;
      md_op = 2'd0;
      mt_hi = 1'b0;
      mt_lo = 1'b0;
      A     = '0;
      B     = '0;
      repeat (2) @(posedge clk);
      #1;
      check("reset_busy", {63'd0, busy}, 64'd0);
      check("reset_hi", {32'd0, HI}, 64'd0);
      check("reset_lo", {32'd0, LO}, 64'd0);
      check("reset_stall", {63'd0, md_stall}, 64'd0);
      reset = 1'b1;

      issue(MD_MULT,  32'hFFFF_FFFE, 32'd3,         1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 5);
      wait_done();
      issue(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFE, 32'h0000_0001, 5);
      wait_done();
      issue(MD_DIV,   32'hFFFF_FFF9, 32'd2,         1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 10);
      wait_done();
      issue(MD_DIVU,  32'd12345,     32'd0,         1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 10);
      wait_done();
      issue(MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'h0000_0000, 32'h8000_0000, 10);
      wait_done();
      issue(MD_DIVU,  32'd100,       32'd7,         1'b0, 32'd2,         32'd14,        10);
      wait_done();

      mt(1'b1, 1'b0, 32'h0000_1234, 32'h0000_1234, 32'd14);
      mt(1'b0, 1'b1, 32'h0000_5678, 32'h0000_1234, 32'h0000_5678);
      mt(1'b1, 1'b1, 32'hAAAA_5555, 32'hAAAA_5555, 32'hAAAA_5555);

      // start together with mthi: the mthi must be dropped
      issue(MD_MULT, 32'd7, 32'd6, 1'b1, 32'd0, 32'h0000_002A, 5);
      wait_done();

      // restart attempt and operand/mt changes mid-run are all ignored
      issue(MD_MULTU, 32'h0001_0000, 32'h0001_0000, 1'b0, 32'd1, 32'd0, 5);
      @(posedge clk); #1;
      start = 1'b1;
      md_op = MD_DIV;
      A     = 32'h0000_0055;
      B     = 32'd3;
      mt_hi = 1'b1;
      mt_lo = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      mt_hi = 1'b0;
      mt_lo = 1'b0;
      check("stall_while_busy", {63'd0, md_stall}, 64'd1);
      wait_done();
      repeat (2) @(posedge clk);
      #1;
      check("no_second_launch", {63'd0, busy}, 64'd0);

      // reset in the middle of a divide
      issue(MD_DIV, 32'd1000, 32'd3, 1'b0, 32'd1, 32'd333, 10);
      @(posedge clk); #1;
      reset = 1'b0;
      #1;
      check("abort_busy", {63'd0, busy}, 64'd0);
      check("abort_hi", {32'd0, HI}, 64'd0);
      check("abort_lo", {32'd0, LO}, 64'd0);
      sb.delete();
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b1;
      issue(MD_DIVU, 32'd9, 32'd4, 1'b0, 32'd1, 32'd2, 10);
      wait_done();

      repeat (3) @(posedge clk);
      #1;
      check("scoreboard_empty", 64'(sb.size()), 64'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
